// File: rtl/datapath_pkg.sv
// Shared types for the multi-cycle datapath: ALU operation codes and the
// memory-handshake FSM states.
package datapath_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLL   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        MEM  = 1'b1
    } dp_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU with compare flags. The flags always come from a-b,
// whatever operation is selected, so branches can use them directly.
module alu_core
    import datapath_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int WIDTH_ALUF = 4
) (
    input  logic [NBITS-1:0]      a,
    input  logic [NBITS-1:0]      b,
    input  logic [WIDTH_ALUF-1:0] alucontrol,
    output logic [NBITS-1:0]      result,
    output logic                  zero,
    output logic                  neg,
    output logic                  carry
);

    localparam int SHW = $clog2(NBITS);

    logic [NBITS:0]   diffExt;
    logic [NBITS-1:0] diff;
    logic             overflow;
    logic [SHW-1:0]   shamt;
    logic [31:0]      opExt;

    // Subtraction as a + ~b + 1 so the carry-out means a >= b unsigned.
    assign diffExt  = {1'b0, a} + {1'b0, ~b} + {{NBITS{1'b0}}, 1'b1};
    assign diff     = diffExt[NBITS-1:0];
    assign carry    = diffExt[NBITS];
    assign zero     = (diff == '0);
    assign overflow = (a[NBITS-1] ^ b[NBITS-1]) & (diff[NBITS-1] ^ a[NBITS-1]);
    assign neg      = diff[NBITS-1] ^ overflow;
    assign shamt    = b[SHW-1:0];
    assign opExt    = 32'(alucontrol);

    always_comb begin
        result = a + b;
        case (opExt)
            32'(ALU_SUB):   result = diff;
            32'(ALU_AND):   result = a & b;
            32'(ALU_OR):    result = a | b;
            32'(ALU_XOR):   result = a ^ b;
            32'(ALU_SLL):   result = a << shamt;
            32'(ALU_SRL):   result = a >> shamt;
            32'(ALU_SRA):   result = $unsigned($signed(a) >>> shamt);
            32'(ALU_SLT):   result = {{(NBITS-1){1'b0}}, neg};
            32'(ALU_SLTU):  result = {{(NBITS-1){1'b0}}, ~carry};
            32'(ALU_PASSB): result = b;
            default:        result = a + b;
        endcase
    end

endmodule

// File: rtl/datapath_mc.sv
// Multi-cycle datapath: register file, ALU and a req/ack data-memory port.
// ALU ops complete in one cycle; loads/stores wait in MEM until mem_ack.
module datapath_mc
    import datapath_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int NREGS      = 32,
    parameter int WIDTH_ALUF = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     valid,
    input  logic [$clog2(NREGS)-1:0] RS1,
    input  logic [$clog2(NREGS)-1:0] RS2,
    input  logic [$clog2(NREGS)-1:0] RD,
    input  logic [NBITS-1:0]         IMM,
    input  logic [WIDTH_ALUF-1:0]    ALUControl,
    input  logic                     ALUSrc,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic                     MemtoReg,
    input  logic                     RegWrite,
    input  logic                     link,
    input  logic [NBITS-1:0]         pclink,
    output logic                     busy,
    output logic                     done,
    output logic                     Zero,
    output logic                     Neg,
    output logic                     Carry,
    output logic [NBITS-1:0]         PCReg,
    output logic [NBITS-3:0]         Address,
    output logic [NBITS-1:0]         WriteData,
    input  logic [NBITS-1:0]         ReadData,
    output logic                     mem_req,
    output logic                     mem_we,
    input  logic                     mem_ack
);

    localparam int RW = $clog2(NREGS);

    logic [NBITS-1:0] regFile [NREGS];
    logic [NBITS-1:0] srcA;
    logic [NBITS-1:0] srcB;
    logic [NBITS-1:0] rdata2;
    logic [NBITS-1:0] aluResult;

    dp_state_t        state;
    dp_state_t        nextState;
    logic [RW-1:0]    rdQ;
    logic             weQ;
    logic             regWriteQ;

    logic             regWe;
    logic [RW-1:0]    wAddr;
    logic [NBITS-1:0] wData;
    logic             doneNext;
    logic             latchMem;

    // Register 0 is never written, so it reads its reset value of zero.
    assign srcA   = regFile[RS1];
    assign rdata2 = regFile[RS2];
    assign srcB   = ALUSrc ? IMM : rdata2;
    assign PCReg  = srcA;

    alu_core #(
        .NBITS      (NBITS),
        .WIDTH_ALUF (WIDTH_ALUF)
    ) u_alu (
        .a          (srcA),
        .b          (srcB),
        .alucontrol (ALUControl),
        .result     (aluResult),
        .zero       (Zero),
        .neg        (Neg),
        .carry      (Carry)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        regWe     = 1'b0;
        wAddr     = RD;
        wData     = aluResult;
        doneNext  = 1'b0;
        latchMem  = 1'b0;
        busy      = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (valid) begin
                    if (MemRead || MemWrite) begin
                        latchMem  = 1'b1;
                        nextState = MEM;
                    end else begin
                        regWe    = RegWrite;
                        wData    = link ? pclink : (MemtoReg ? ReadData : aluResult);
                        doneNext = 1'b1;
                    end
                end
            end
            MEM: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                mem_we  = weQ;
                // A request with both MemRead and MemWrite is a store: no write-back.
                if (mem_ack) begin
                    regWe     = regWriteQ & ~weQ;
                    wAddr     = rdQ;
                    wData     = ReadData;
                    doneNext  = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regFile[i] <= '0;
            end
            done      <= 1'b0;
            Address   <= '0;
            WriteData <= '0;
            rdQ       <= '0;
            weQ       <= 1'b0;
            regWriteQ <= 1'b0;
        end else begin
            done <= doneNext;
            if (regWe && (wAddr != '0)) begin
                regFile[wAddr] <= wData;
            end
            if (latchMem) begin
                Address   <= aluResult[NBITS-1:2];
                WriteData <= rdata2;
                rdQ       <= RD;
                weQ       <= MemWrite;
                regWriteQ <= RegWrite;
            end
        end
    end

endmodule

// File: tb/tb_datapath_mc.sv
// Directed bench for datapath_mc: stimulus pushes the expected done cycle,
// a monitor pops it whenever done pulses; register contents read via PCReg.
module tb_datapath_mc;
    import datapath_pkg::*;

    localparam int NBITS      = 32;
    localparam int NREGS      = 32;
    localparam int WIDTH_ALUF = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              valid;
    logic [4:0]        RS1, RS2, RD;
    logic [NBITS-1:0]  IMM;
    logic [3:0]        ALUControl;
    logic              ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, link;
    logic [NBITS-1:0]  pclink;
    logic              busy, done, Zero, Neg, Carry;
    logic [NBITS-1:0]  PCReg;
    logic [NBITS-3:0]  Address;
    logic [NBITS-1:0]  WriteData;
    logic [NBITS-1:0]  ReadData;
    logic              mem_req, mem_we, mem_ack;

    int                checks = 0;
    int                errors = 0;
    int unsigned       cyc = 0;
    int unsigned       expDone [$];
    int unsigned       expCyc;

    datapath_mc #(
        .NBITS      (NBITS),
        .NREGS      (NREGS),
        .WIDTH_ALUF (WIDTH_ALUF)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .valid      (valid),
        .RS1        (RS1),
        .RS2        (RS2),
        .RD         (RD),
        .IMM        (IMM),
        .ALUControl (ALUControl),
        .ALUSrc     (ALUSrc),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .link       (link),
        .pclink     (pclink),
        .busy       (busy),
        .done       (done),
        .Zero       (Zero),
        .Neg        (Neg),
        .Carry      (Carry),
        .PCReg      (PCReg),
        .Address    (Address),
        .WriteData  (WriteData),
        .ReadData   (ReadData),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_ack    (mem_ack)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the next expected cycle.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (expDone.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
            end else begin
                expCyc = expDone.pop_front();
                checkOutput("done_cycle", 64'(cyc), 64'(expCyc));
            end
        end
    end

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic [31:0] imm,
                                 input logic [3:0] aluc, input logic alusrc,
                                 input logic mr, input logic mw, input logic m2r,
                                 input logic rw, input logic lnk, input logic [31:0] pcl);
        RS1 = rs1; RS2 = rs2; RD = rd; IMM = imm; ALUControl = aluc;
        ALUSrc = alusrc; MemRead = mr; MemWrite = mw; MemtoReg = m2r;
        RegWrite = rw; link = lnk; pclink = pcl;
        valid = 1'b1;
        if (!(mr || mw)) expDone.push_back(cyc + 1);
        @(negedge clock);
        valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0;
        RegWrite = 1'b0; link = 1'b0;
    endtask

    task automatic aluOp(input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input alu_op_t op);
        applyStimulus(rs1, rs2, rd, 32'd0, op, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic aluImm(input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [31:0] imm, input alu_op_t op);
        applyStimulus(rs1, 5'd0, rd, imm, op, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    endtask

    task automatic checkReg(input logic [4:0] r, input logic [31:0] expected, input string name);
        RS1 = r;
        #1;
        checkOutput(name, 64'(PCReg), 64'(expected));
    endtask

    task automatic checkFlags(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic z, input logic n, input logic c, input string name);
        RS1 = rs1; RS2 = rs2; ALUSrc = 1'b0;
        #1;
        checkOutput({name, "_zero"},  64'(Zero),  64'(z));
        checkOutput({name, "_neg"},   64'(Neg),   64'(n));
        checkOutput({name, "_carry"}, 64'(Carry), 64'(c));
    endtask

    // Called in the first MEM cycle; acks after the given wait cycles.
    task automatic memTransaction(input int waits, input logic [31:0] rdata,
                                  input logic [29:0] expAddr, input logic expWe,
                                  input logic [31:0] expWd, input logic inject);
        int reqCount = 0;
        #1;
        checkOutput("mem_req_rise", 64'(mem_req), 64'd1);
        checkOutput("busy_rise",    64'(busy),    64'd1);
        checkOutput("mem_addr",     64'(Address), 64'(expAddr));
        checkOutput("mem_we",       64'(mem_we),  64'(expWe));
        if (expWe) checkOutput("mem_wdata", 64'(WriteData), 64'(expWd));
        for (int i = 0; i < waits; i++) begin
            if (mem_req) reqCount++;
            if (inject && i == 0) begin
                RS1 = 5'd0; RD = 5'd10; IMM = 32'd99; ALUSrc = 1'b1;
                ALUControl = ALU_ADD; RegWrite = 1'b1; valid = 1'b1;
            end
            @(negedge clock);
            valid = 1'b0; RegWrite = 1'b0;
        end
        checkOutput("mem_addr_hold", 64'(Address), 64'(expAddr));
        if (mem_req) reqCount++;
        mem_ack  = 1'b1;
        ReadData = rdata;
        expDone.push_back(cyc + 1);
        @(negedge clock);
        mem_ack = 1'b0;
        #1;
        checkOutput("busy_after_ack",    64'(busy),     64'd0);
        checkOutput("mem_req_after_ack", 64'(mem_req),  64'd0);
        checkOutput("mem_req_cycles",    64'(reqCount), 64'(waits + 1));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; valid = 1'b0; RS1 = '0; RS2 = '0; RD = '0; IMM = '0;
        ALUControl = '0; ALUSrc = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        MemtoReg = 1'b0; RegWrite = 1'b0; link = 1'b0; pclink = '0;
        ReadData = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("reset_busy",    64'(busy),    64'd0);
        checkOutput("reset_mem_req", 64'(mem_req), 64'd0);
        checkOutput("reset_mem_we",  64'(mem_we),  64'd0);
        checkOutput("reset_done",    64'(done),    64'd0);
        checkOutput("reset_addr",    64'(Address), 64'd0);
        for (int r = 0; r < NREGS; r++) checkReg(5'(r), 32'd0, "reset_reg");

        @(negedge clock);
        aluImm(5'd1, 5'd0, 32'd5, ALU_ADD);
        aluOp(5'd2, 5'd1, 5'd1, ALU_SUB);
        checkReg(5'd1, 32'd5, "addi_r1");
        checkReg(5'd2, 32'd0, "sub_r2");
        checkFlags(5'd1, 5'd1, 1'b1, 1'b0, 1'b1, "flags_eq");

        aluImm(5'd3, 5'd0, 32'h7FFF_FFFF, ALU_ADD);
        aluImm(5'd4, 5'd0, 32'h8000_0000, ALU_ADD);
        aluOp(5'd6, 5'd3, 5'd4, ALU_SLT);
        aluOp(5'd7, 5'd3, 5'd4, ALU_SLTU);
        aluImm(5'd8, 5'd4, 32'd4, ALU_SRA);
        aluImm(5'd9, 5'd1, 32'd3, ALU_SLL);
        aluOp(5'd13, 5'd3, 5'd4, ALU_XOR);
        aluImm(5'd14, 5'd4, 32'd31, ALU_SRL);
        aluImm(5'd15, 5'd0, 32'h55, ALU_PASSB);
        aluImm(5'd16, 5'd1, 32'h0C, ALU_AND);
        aluImm(5'd0, 5'd0, 32'd7, ALU_ADD);
        checkReg(5'd3,  32'h7FFF_FFFF, "r3");
        checkReg(5'd4,  32'h8000_0000, "r4");
        checkReg(5'd6,  32'd0,         "slt");
        checkReg(5'd7,  32'd1,         "sltu");
        checkReg(5'd8,  32'hF800_0000, "sra");
        checkReg(5'd9,  32'd40,        "sll");
        checkReg(5'd13, 32'hFFFF_FFFF, "xor");
        checkReg(5'd14, 32'd1,         "srl");
        checkReg(5'd15, 32'h55,        "passb");
        checkReg(5'd16, 32'd4,         "andi");
        checkReg(5'd0,  32'd0,         "r0_write_discard");
        checkFlags(5'd3, 5'd4, 1'b0, 1'b0, 1'b0, "flags_ovf");

        // Store r1 to 0x10 with three wait cycles and an ignored issue while busy.
        applyStimulus(5'd0, 5'd1, 5'd0, 32'h10, ALU_ADD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        memTransaction(3, 32'd0, 30'h4, 1'b1, 32'd5, 1'b1);
        checkReg(5'd10, 32'd0, "valid_while_busy");

        applyStimulus(5'd0, 5'd0, 5'd5, 32'h10, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        memTransaction(0, 32'd5, 30'h4, 1'b0, 32'd0, 1'b0);
        checkReg(5'd5, 32'd5, "load_r5");

        applyStimulus(5'd0, 5'd0, 5'd0, 32'h10, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        memTransaction(1, 32'hDEAD, 30'h4, 1'b0, 32'd0, 1'b0);
        checkReg(5'd0, 32'd0, "load_r0");

        applyStimulus(5'd1, 5'd1, 5'd12, 32'd0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1234);
        checkReg(5'd12, 32'h1234, "link");

        // Reset in the middle of a load aborts it without write-back or done.
        applyStimulus(5'd0, 5'd0, 5'd11, 32'h20, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        #1;
        checkOutput("abort_req_before", 64'(mem_req), 64'd1);
        reset = 1'b1;
        #1;
        checkOutput("abort_req_drop",  64'(mem_req), 64'd0);
        checkOutput("abort_busy_drop", 64'(busy),    64'd0);
        @(negedge clock);
        reset = 1'b0;
        checkReg(5'd12, 32'd0, "reset_clears_r12");
        mem_ack = 1'b1;
        ReadData = 32'h77;
        @(negedge clock);
        mem_ack = 1'b0;
        #1;
        checkOutput("ack_in_idle_busy", 64'(busy), 64'd0);
        checkReg(5'd11, 32'd0, "abort_no_writeback");
        repeat (3) @(negedge clock);
        #1;
        checkOutput("scoreboard_drain", 64'(expDone.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_mc.md
# datapath_mc

Parametrised multi-cycle datapath: register file, full-function ALU with branch flags, and a request/acknowledge data-memory port for loads and stores that may stall for any number of cycles. Sits between the controller (operands, control strobes, PC link value) and the data memory/cache. Generalises the single-cycle datapath with configurable width and depth, a complete ALU operation set, MemtoReg write-back and an explicit issue/busy/done handshake.

## Interface
- NBITS, 32, data/register width (≥8)
- NREGS, 32, register count (power of two, ≥2)
- WIDTH_ALUF, 4, ALUControl width
- clock  in  1  single clock; all state on posedge
- reset  in  1  asynchronous, active-high
- valid  in  1  issue strobe; accepted only when busy=0
- RS1, RS2, RD  in  $clog2(NREGS)  register indices
- IMM  in  NBITS signed  immediate
- ALUControl  in  WIDTH_ALUF  ALU operation
- ALUSrc, MemRead, MemWrite, MemtoReg, RegWrite, link  in  1  controls, sampled at issue
- pclink  in  NBITS  PC value written to RD when link=1
- busy  out  1  memory op in flight
- done  out  1  one-cycle completion pulse
- Zero, Neg, Carry  out  1  compare flags of SrcA−SrcB
- PCReg  out  NBITS  register[RS1], combinational
- Address  out  NBITS-2  word address [NBITS-1:2]
- WriteData  out  NBITS  store data
- ReadData  in  NBITS  load data, valid with mem_ack
- mem_req, mem_we  out  1  memory request / write qualifier
- mem_ack  in  1  memory accepts/completes request

## Operation
- SrcA=register[RS1]; SrcB=ALUSrc ? IMM : register[RS2]; register 0 reads 0, writes discarded.
- ALU ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 PASSB; other codes = ADD. Shift amount = SrcB[$clog2(NBITS)-1:0]. Results truncated to NBITS.
- Flags always from SrcA+~SrcB+1, independent of ALUControl: Zero=(SrcA==SrcB); Neg=signed SrcA<SrcB (overflow-corrected); Carry=carry-out (1 ⇔ SrcA≥SrcB unsigned).
- Write-back value: link ? pclink : MemtoReg ? ReadData : ALUResult.
- FSM IDLE/MEM. IDLE+valid, no MemRead/MemWrite: RD written if RegWrite; stay IDLE. IDLE+valid with MemRead or MemWrite: latch Address=ALUResult[NBITS-1:2], WriteData=register[RS2], RD, control bits; go MEM. Low address bits ignored.
- MEM: mem_req=1, mem_we=latched MemWrite, held stable until mem_ack. On mem_ack: load writes ReadData to latched RD if RegWrite; → IDLE.
- MemRead and MemWrite both set: treated as store; no register write for stores.
- valid while busy=1 ignored (controller must hold off).

## Timing
- Reset (async): all registers 0, state IDLE, busy/done/mem_req/mem_we 0, Address/WriteData 0.
- ALU op issued cycle N: RD updated at end of N; done=1 in N+1.
- Memory op issued N: busy and mem_req high from N+1; ack in cycle M≥N+1 → RD written end of M, done=1 and busy=0 in M+1; next issue allowed in M+1. Minimum memory latency 2 cycles.
- mem_ack outside MEM ignored. Reset mid-MEM aborts: mem_req drops immediately, no write-back, no done.
- Write and read of same register in one cycle: read returns old value (no bypass).

## Structure
- Package datapath_pkg: alu_op_t enum (codes above), dp_state_t {IDLE, MEM}.
- Sub-module alu_core: combinational ALU + flag generation, parametrised on NBITS.

## Test plan
- Reset then read all registers via PCReg → every value 0; busy=0, mem_req=0.
- ADDI r1=r0+5, then SUB r2=r1−r1 → r2=0; compare r1,r1: Zero=1, Neg=0, Carry=1.
- r3=0x7FFFFFFF, r4=0x80000000: SLT r3,r4 → 0, SLTU → 1; Neg=0, Carry=0; SRA r4 by 4 → 0xF8000000.
- Store r1 to addr 0x10, mem_ack after 3 wait cycles → mem_req high 3 cycles plus ack cycle, Address=0x4, mem_we=1, done one cycle after ack.
- Load addr 0x10 into r5, ReadData=5 with ack in first MEM cycle → r5=5, done two cycles after issue; load into r0 → r0 stays 0.
- Assert reset during MEM → mem_req low immediately, no done; valid during busy ignored; link=1 writes pclink to RD.
